// File: rtl/traffic_light_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_pkg
// Description : Shared types and constants for the traffic-light Avalon-MM
//               sequencer: phase encoding, bus FSM states, light patterns
//               and the decimal-to-BCD helper used to preload durations.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_light_pkg;

  // Current light phase
  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2
  } phase_e;

  // Bus sequencer states, kept as plain constants for legacy tools
  typedef logic [1:0] bus_state_t;
  localparam bus_state_t c_BUS_IDLE    = 2'd0;
  localparam bus_state_t c_BUS_WR_ONES = 2'd1;
  localparam bus_state_t c_BUS_WR_TENS = 2'd2;
  localparam bus_state_t c_BUS_WR_LED  = 2'd3;

  // {red,yellow,green}
  localparam logic [2:0] c_LIGHT_RED    = 3'b100;
  localparam logic [2:0] c_LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] c_LIGHT_YELLOW = 3'b010;

  // Decimal value 0..99 to {tens, ones} BCD pair
  function automatic logic [7:0] dec_to_bcd(input int unsigned value);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'((value / 10) % 10);
    ones = 4'(value % 10);
    return {tens, ones};
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_tick_gen
// Description : Prescaler producing a one-cycle tick every TICK_DIV enabled
//               clock cycles. Count holds while enable_i is low.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               enable_i - 1 = prescaler counts, 0 = frozen
//               tick_o   - one-cycle pulse on terminal count
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] c_TERMINAL = CNT_W'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 1");
  end

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             at_term;

  assign at_term = (count_q == c_TERMINAL);

  always_comb begin
    count_d = count_q;
    if (enable_i) begin
      count_d = at_term ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = enable_i && at_term;

endmodule
`default_nettype wire

// File: rtl/traffic_light_avm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_avm_sequencer
// Description : Avalon-MM master running the RED->GREEN->YELLOW phase machine
//               with a BCD per-second countdown. After each displayed change
//               it writes the ones digit, tens digit and light pattern to the
//               PIO slave data registers as three back-to-back single writes.
// Ports       : clk, reset_n         - clock, async active-low reset
//               enable               - countdown runs when high
//               avm_address/write/writedata/byteenable - master write port
//               avm_waitrequest      - slave stall
//               lights_out           - {red,yellow,green} current phase
//               busy                 - write sequence in progress
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_avm_sequencer
  import traffic_light_pkg::*;
#(
  parameter int unsigned         TICK_DIV  = 50000000,
  parameter int unsigned         RED_S     = 9,
  parameter int unsigned         GREEN_S   = 7,
  parameter int unsigned         YELLOW_S  = 3,
  parameter int unsigned         ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]   HEX0_BASE = 'h0000,
  parameter logic [ADDR_W-1:0]   HEX1_BASE = 'h0010,
  parameter logic [ADDR_W-1:0]   LED_BASE  = 'h0020
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic [2:0]        lights_out,
  output logic              busy
);

  if (RED_S < 1 || RED_S > 99) begin : g_bad_red_s
    $error("RED_S must be in 1..99");
  end
  if (GREEN_S < 1 || GREEN_S > 99) begin : g_bad_green_s
    $error("GREEN_S must be in 1..99");
  end
  if (YELLOW_S < 1 || YELLOW_S > 99) begin : g_bad_yellow_s
    $error("YELLOW_S must be in 1..99");
  end

  localparam logic [7:0] c_RED_BCD    = dec_to_bcd(RED_S);
  localparam logic [7:0] c_GREEN_BCD  = dec_to_bcd(GREEN_S);
  localparam logic [7:0] c_YELLOW_BCD = dec_to_bcd(YELLOW_S);

  logic       tick;
  phase_e     phase_q, phase_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       pending_q, pending_d;
  bus_state_t state_q, state_d;
  logic [3:0] snap_ones_q, snap_ones_d;
  logic [3:0] snap_tens_q, snap_tens_d;
  logic [2:0] snap_lights_q, snap_lights_d;
  logic [2:0] lights;
  logic       count_is_one;
  logic       start_seq;

  traffic_light_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable_i (enable),
    .tick_o   (tick)
  );

  // Light pattern follows the phase register directly, not the bus
  always_comb begin
    lights = c_LIGHT_RED;
    case (phase_q)
      PH_GREEN:  lights = c_LIGHT_GREEN;
      PH_YELLOW: lights = c_LIGHT_YELLOW;
      default:   lights = c_LIGHT_RED;
    endcase
  end

  assign lights_out   = lights;
  assign count_is_one = (tens_q == 4'd0) && (ones_q == 4'd1);

  // Countdown: display runs duration..1; reaching 1 hands over to next phase
  always_comb begin
    phase_d = phase_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    if (tick) begin
      if (count_is_one) begin
        case (phase_q)
          PH_RED: begin
            phase_d          = PH_GREEN;
            {tens_d, ones_d} = c_GREEN_BCD;
          end
          PH_GREEN: begin
            phase_d          = PH_YELLOW;
            {tens_d, ones_d} = c_YELLOW_BCD;
          end
          default: begin
            phase_d          = PH_RED;
            {tens_d, ones_d} = c_RED_BCD;
          end
        endcase
      end else if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 1'b1;
      end else begin
        ones_d = ones_q - 1'b1;
      end
    end
  end

  assign start_seq = (state_q == c_BUS_IDLE) && pending_q;

  // A tick in the consuming cycle re-arms pending (set wins over clear)
  always_comb begin
    pending_d = pending_q;
    if (tick) begin
      pending_d = 1'b1;
    end else if (start_seq) begin
      pending_d = 1'b0;
    end
  end

  // Snapshot holds the values for the whole sequence even if ticks arrive
  always_comb begin
    snap_ones_d   = snap_ones_q;
    snap_tens_d   = snap_tens_q;
    snap_lights_d = snap_lights_q;
    if (start_seq) begin
      snap_ones_d   = ones_q;
      snap_tens_d   = tens_q;
      snap_lights_d = lights;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_BUS_IDLE:    if (pending_q)        state_d = c_BUS_WR_ONES;
      c_BUS_WR_ONES: if (!avm_waitrequest) state_d = c_BUS_WR_TENS;
      c_BUS_WR_TENS: if (!avm_waitrequest) state_d = c_BUS_WR_LED;
      c_BUS_WR_LED:  if (!avm_waitrequest) state_d = c_BUS_IDLE;
      default:                             state_d = c_BUS_IDLE;
    endcase
  end

  // Outputs decode straight from state so reset drops avm_write immediately
  always_comb begin
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = 4'b0000;
    case (state_q)
      c_BUS_WR_ONES: begin
        avm_write      = 1'b1;
        avm_address    = HEX0_BASE;
        avm_writedata  = {28'b0, snap_ones_q};
        avm_byteenable = 4'b1111;
      end
      c_BUS_WR_TENS: begin
        avm_write      = 1'b1;
        avm_address    = HEX1_BASE;
        avm_writedata  = {28'b0, snap_tens_q};
        avm_byteenable = 4'b1111;
      end
      c_BUS_WR_LED: begin
        avm_write      = 1'b1;
        avm_address    = LED_BASE;
        avm_writedata  = {29'b0, snap_lights_q};
        avm_byteenable = 4'b1111;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != c_BUS_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q       <= PH_RED;
      tens_q        <= c_RED_BCD[7:4];
      ones_q        <= c_RED_BCD[3:0];
      pending_q     <= 1'b1;
      state_q       <= c_BUS_IDLE;
      snap_ones_q   <= 4'd0;
      snap_tens_q   <= 4'd0;
      snap_lights_q <= 3'd0;
    end else begin
      phase_q       <= phase_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      pending_q     <= pending_d;
      state_q       <= state_d;
      snap_ones_q   <= snap_ones_d;
      snap_tens_q   <= snap_tens_d;
      snap_lights_q <= snap_lights_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_avm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_avm_sequencer
// Description : Scoreboard bench for traffic_light_avm_sequencer. Two
//               instances (RED_S=9 and RED_S=12, TICK_DIV=4) share stimulus.
//               A decimal countdown model predicts each write sequence and
//               queues the expected writes; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_avm_sequencer;

  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        waitreq;
  logic        wr     [2];
  logic [15:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [3:0]  be     [2];
  logic [2:0]  lights [2];
  logic        busy   [2];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  traffic_light_avm_sequencer #(.TICK_DIV(TICK_DIV)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .avm_address(addr[0]), .avm_write(wr[0]), .avm_writedata(wdata[0]),
    .avm_byteenable(be[0]), .avm_waitrequest(waitreq),
    .lights_out(lights[0]), .busy(busy[0]));

  traffic_light_avm_sequencer #(.TICK_DIV(TICK_DIV), .RED_S(12)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .avm_address(addr[1]), .avm_write(wr[1]), .avm_writedata(wdata[1]),
    .avm_byteenable(be[1]), .avm_waitrequest(waitreq),
    .lights_out(lights[1]), .busy(busy[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (decimal, transaction level) ----------
  int          m_cnt  [2];
  int          m_ph   [2];   // 0 red, 1 green, 2 yellow
  int          m_rem  [2];   // writes left in current sequence
  int          m_cyc  [2];
  bit          m_pend [2];
  logic [47:0] fifo   [2][64];
  int          wp     [2];
  int          rp     [2];

  function automatic int dur(input int k, input int ph);
    if (ph == 0) return (k == 1) ? 12 : 9;
    if (ph == 1) return 7;
    return 3;
  endfunction

  function automatic logic [2:0] light_of(input int ph);
    if (ph == 0) return 3'b100;
    if (ph == 1) return 3'b001;
    return 3'b010;
  endfunction

  task automatic push(input int k, input logic [15:0] a, input logic [31:0] d);
    fifo[k][wp[k] % 64] = {a, d};
    wp[k]++;
  endtask

  // At each negedge: check state after the last posedge, then advance the
  // model to what the next posedge should produce.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_ph[k] = 0; m_cnt[k] = dur(k, 0); m_rem[k] = 0; m_cyc[k] = 0; m_pend[k] = 1'b1;
      end else begin
        chk($sformatf("lights%0d", k), lights[k], light_of(m_ph[k]));
        chk($sformatf("busy%0d", k), busy[k], (m_rem[k] > 0));
        if (m_rem[k] == 0) begin
          if (m_pend[k]) begin
            push(k, 16'h0000, 32'(m_cnt[k] % 10));
            push(k, 16'h0010, 32'(m_cnt[k] / 10));
            push(k, 16'h0020, {29'b0, light_of(m_ph[k])});
            m_rem[k]  = 3;
            m_pend[k] = 1'b0;
          end
        end else if (!waitreq) begin
          m_rem[k]--;
        end
        if (enable) begin
          m_cyc[k]++;
          if (m_cyc[k] == TICK_DIV) begin
            m_cyc[k] = 0;
            m_cnt[k]--;
            if (m_cnt[k] == 0) begin
              m_ph[k]  = (m_ph[k] + 1) % 3;
              m_cnt[k] = dur(k, m_ph[k]);
            end
            m_pend[k] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- monitor ------------------------------------------------
  bit          stall_prev [2];
  logic [15:0] prev_addr  [2];
  logic [31:0] prev_data  [2];
  int          nwrites = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        rp[k] = 0; wp[k] = 0; stall_prev[k] = 1'b0;
      end else begin
        if (stall_prev[k]) begin
          chk($sformatf("hold_wr%0d", k), wr[k], 1'b1);
          chk($sformatf("hold_addr%0d", k), addr[k], prev_addr[k]);
          chk($sformatf("hold_data%0d", k), wdata[k], prev_data[k]);
        end
        if (wr[k] && !waitreq) begin
          nwrites++;
          if (rp[k] == wp[k]) begin
            chk($sformatf("unexpected_write%0d", k), {addr[k], wdata[k]}, 48'h0);
          end else begin
            logic [47:0] e;
            e = fifo[k][rp[k] % 64];
            rp[k]++;
            chk($sformatf("wr_addr%0d", k), addr[k], e[47:32]);
            chk($sformatf("wr_data%0d", k), wdata[k], e[31:0]);
            chk($sformatf("wr_be%0d", k), be[k], 4'hF);
          end
        end
        stall_prev[k] = wr[k] && waitreq;
        prev_addr[k]  = addr[k];
        prev_data[k]  = wdata[k];
      end
    end
  end

  // ---------------- stimulus -----------------------------------------------
  task automatic run(input int n, input int stall_pct, input int off_pct);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      waitreq = ($urandom_range(0, 99) < stall_pct);
      enable  = !($urandom_range(0, 99) < off_pct);
    end
  endtask

  task automatic hold_stall(input int n);
    @(posedge clk); #1;
    waitreq = 1'b1;
    enable  = 1'b1;
    repeat (n) @(posedge clk);
    #1 waitreq = 1'b0;
  endtask

  initial begin
    bit found;
    reset_n = 1'b0;
    enable  = 1'b1;
    waitreq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_write%0d", k), wr[k], 1'b0);
      chk($sformatf("rst_addr%0d", k), addr[k], 16'h0);
      chk($sformatf("rst_data%0d", k), wdata[k], 32'h0);
      chk($sformatf("rst_be%0d", k), be[k], 4'h0);
      chk($sformatf("rst_lights%0d", k), lights[k], 3'b100);
      chk($sformatf("rst_busy%0d", k), busy[k], 1'b0);
    end
    reset_n = 1'b1;

    run(120, 0, 0);
    run(600, 40, 0);
    for (int j = 0; j < 8; j++) begin
      run(20, 10, 0);
      hold_stall(14);
    end
    for (int j = 0; j < 10; j++) begin
      run(15, 20, 0);
      @(posedge clk); #1;
      enable = 1'b0;
      repeat ($urandom_range(3, 12)) @(posedge clk);
      #1 enable = 1'b1;
    end

    // Reset while dut0 is stalled in its ones-digit write
    found = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #1;
      if (wr[0] && addr[0] == 16'h0000) begin
        waitreq = 1'b1;
        found   = 1'b1;
      end else begin
        waitreq = 1'b0;
      end
    end
    chk("wr_ones_reached", found, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_drop_write0", wr[0], 1'b0);
    chk("async_drop_write1", wr[1], 1'b0);
    chk("async_drop_busy0", busy[0], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    waitreq = 1'b0;

    run(400, 30, 10);

    // Drain everything still queued
    @(posedge clk); #1;
    enable  = 1'b0;
    waitreq = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("drained%0d", k), rp[k], wp[k]);
    end
    chk("writes_seen", (nwrites > 100), 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    nerr++;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
